writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Parametrised writeback stage: selects one of NSRC result sources, aligns and extends load data,
//  waits for late memory read data and registers the final GPR write.
//  Sits between the memory stage and the register file.
//  Drives the GPR write port and the WB->EX forwarding path.
// PARAMETERS
//  DATA_W   32  datapath width; must be 32 (load alignment assumes 4 byte lanes)
//  NSRC     4   number of result sources (ALU, shifter, memory, link, ...)
//  SEL_W    $clog2(NSRC)  width of source select
//  REG_AW   5   GPR address width
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous active-low reset
//  flush      in   1              drop the pending load / incoming op
//  in_valid   in   1              op from MEM stage valid
//  in_ready   out  1              unit can accept an op this cycle
//  src_data   in   NSRC*DATA_W    packed sources; source k = [k*DATA_W +: DATA_W]
//  src_sel    in   SEL_W          source index for non-load ops
//  is_load    in   1              op takes its result from mem_rdata
//  load_size  in   2              00 byte, 01 half, 10 word (11 treated as word)
//  load_sign  in   1              1 sign-extend, 0 zero-extend (byte/half)
//  addr_lo    in   2              low byte-address bits of the load
//  reg_we     in   1              op writes a GPR
//  dest_reg   in   REG_AW         destination register
//  mem_rvalid in   1              mem_rdata valid this cycle
//  mem_rdata  in   DATA_W         raw memory read word
//  gpr_we     out  1              register-file write enable (one-cycle pulse)
//  gpr_waddr  out  REG_AW         register-file write address
//  gpr_wdata  out  DATA_W         register-file write data
//  busy       out  1              high while in WAIT_MEM (used by hazard unit to stall)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; gpr_we=0, gpr_waddr=0, gpr_wdata=0, busy=0.
//    in_ready=0 during reset. A reset mid-WAIT_MEM abandons the load with no write.
//  - States:
//      IDLE:     in_ready=1.
//      WAIT_MEM: in_ready=0, busy=1.
//  - Accept: in_valid & in_ready & ~flush.
//  - Non-load accept: next cycle gpr_we=reg_we & (dest_reg!=0), gpr_waddr=dest_reg,
//    gpr_wdata=source[src_sel]. Latency 1. src_sel>=NSRC selects 32'b0.
//  - Load accept with mem_rvalid=1 in the same cycle: same as non-load, data=aligned mem_rdata. Latency 1.
//  - Load accept with mem_rvalid=0: latch dest_reg, reg_we, load_size, load_sign and addr_lo;
//    go to WAIT_MEM.
//  - WAIT_MEM: on mem_rvalid, the next cycle gpr_we pulses with the aligned data; return to IDLE.
//    mem_rvalid while in IDLE with no load accepted is ignored.
//  - Alignment:
//      byte = mem_rdata[8*addr_lo +: 8]
//      half = mem_rdata[16*addr_lo[1] +: 16]  (addr_lo[0] ignored)
//      word = mem_rdata
//    Extend to DATA_W: replicate the MSB if load_sign, else zeros.
//  - Writes to register 0 never assert gpr_we.
//  - gpr_we is high for exactly one cycle per committed op; gpr_waddr and gpr_wdata hold their
//    last values when gpr_we=0.
//  - flush (priority below reset, above everything else):
//      in IDLE: blocks the accept.
//      in WAIT_MEM: returns to IDLE and no write occurs, even if mem_rvalid is high that cycle.
//  - Back-to-back non-load ops sustain one write per cycle.
// TESTING
//  1. ALU op src_sel=0, src0=0x0000_1234, dest=5 -> next cycle gpr_we=1, waddr=5, wdata=0x0000_1234.
//  2. src_sel=3 (link) with src3=0x0040_0008, dest=31; then dest=0 op
//     -> first writes 0x0040_0008 to r31; second gives gpr_we=0.
//  3. lb, addr_lo=2, signed, mem_rdata=0x1280_3456 arrives with the op
//     -> wdata=0xFFFF_FF80; lbu same -> 0x0000_0080.
//  4. lh, addr_lo=2, signed, mem_rvalid 3 cycles late, mem_rdata=0x8001_0000
//     -> busy/in_ready=0 for 3 cycles, then wdata=0xFFFF_8001, gpr_we one cycle.
//  5. Load pending in WAIT_MEM, flush=1 and mem_rvalid=1 in the same cycle
//     -> no gpr_we; in_ready=1 the next cycle.
//  6. rst_n=0 asserted in WAIT_MEM -> all outputs 0, state IDLE; a later mem_rvalid produces no write.

Source files
------------

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   Writeback stage between the memory stage and the register file. It picks
//   one of NSRC result sources, aligns and extends load data, parks a load
//   whose read data has not yet arrived (WAIT_MEM) and drives a registered
//   GPR write port that also feeds the WB->EX forwarding path.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   flush               drops the pending load / blocks the incoming op
//   in_valid, in_ready  op handshake from the MEM stage
//   src_data, src_sel   packed result sources and the index for non-load ops
//   is_load, load_size, load_sign, addr_lo   load description
//   reg_we, dest_reg    GPR write request of the incoming op
//   mem_rvalid, mem_rdata  memory read return
//   gpr_we, gpr_waddr, gpr_wdata  registered register-file write port
//   busy                high while a load waits for its data
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int SEL_W  = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int REG_AW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       src_sel,
  input  logic                   is_load,
  input  logic [1:0]             load_size,
  input  logic                   load_sign,
  input  logic [1:0]             addr_lo,
  input  logic                   reg_we,
  input  logic [REG_AW-1:0]      dest_reg,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   gpr_we,
  output logic [REG_AW-1:0]      gpr_waddr,
  output logic [DATA_W-1:0]      gpr_wdata,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01
  } state_t;

  localparam int NSEL = 1 << SEL_W;

  state_t              state;
  logic [REG_AW-1:0]   pend_dest;
  logic                pend_we;
  logic [1:0]          pend_size;
  logic                pend_sign;
  logic [1:0]          pend_lo;

  logic [DATA_W-1:0]   src_arr [NSEL];
  logic                in_accept;
  logic [DATA_W-1:0]   now_load_data;
  logic [DATA_W-1:0]   pend_load_data;
  logic                commit;
  logic [REG_AW-1:0]   commit_dest;
  logic [DATA_W-1:0]   commit_data;

  // Select the addressed byte/half/word lane and sign- or zero-extend it.
  // Halfword selection only looks at lo[1]; lo[0] is ignored.
  function automatic logic [DATA_W-1:0] align_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        lo
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[8*lo +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{(DATA_W-8){sgn & b[7]}}, b};
      2'b01:   r = {{(DATA_W-16){sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Unpack the sources; select codes with no source behind them read as zero.
  for (genvar k = 0; k < NSEL; k++) begin : g_src
    if (k < NSRC) begin : g_real
      assign src_arr[k] = src_data[k*DATA_W +: DATA_W];
    end else begin : g_zero
      assign src_arr[k] = {DATA_W{1'b0}};
    end
  end

  assign in_accept      = in_valid & in_ready & ~flush;
  assign now_load_data  = align_load(mem_rdata, load_size, load_sign, addr_lo);
  assign pend_load_data = align_load(mem_rdata, pend_size, pend_sign, pend_lo);

  // Decide whether a GPR write commits on the coming edge and with what
  // address/data; writes to r0 are suppressed here.
  always_comb begin
    commit      = 1'b0;
    commit_dest = dest_reg;
    commit_data = src_arr[src_sel];
    if (state == WAIT_MEM) begin
      commit      = ~flush & mem_rvalid & pend_we & (pend_dest != {REG_AW{1'b0}});
      commit_dest = pend_dest;
      commit_data = pend_load_data;
    end else begin
      commit      = in_accept & reg_we & (dest_reg != {REG_AW{1'b0}}) &
                    (~is_load | mem_rvalid);
      commit_dest = dest_reg;
      commit_data = is_load ? now_load_data : src_arr[src_sel];
    end
  end

  // Control FSM with registered handshake, busy and GPR write outputs.
  // in_ready/busy are registered from the next state, so they come up
  // one cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      gpr_we    <= 1'b0;
      gpr_waddr <= {REG_AW{1'b0}};
      gpr_wdata <= {DATA_W{1'b0}};
      pend_dest <= {REG_AW{1'b0}};
      pend_we   <= 1'b0;
      pend_size <= 2'b00;
      pend_sign <= 1'b0;
      pend_lo   <= 2'b00;
    end else begin
      gpr_we <= commit;
      // Address and data only move on a real write so they hold otherwise.
      if (commit) begin
        gpr_waddr <= commit_dest;
        gpr_wdata <= commit_data;
      end
      case (state)
        IDLE: begin
          if (in_accept && is_load && !mem_rvalid) begin
            state     <= WAIT_MEM;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            pend_dest <= dest_reg;
            pend_we   <= reg_we;
            pend_size <= load_size;
            pend_sign <= load_sign;
            pend_lo   <= addr_lo;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        WAIT_MEM: begin
          // flush abandons the load even when the data shows up this cycle;
          // the commit logic already masks the write in that case.
          if (flush || mem_rvalid) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready;
  logic [NS*DW-1:0] src_data;
  logic [SW-1:0]   src_sel;
  logic            is_load;
  logic [1:0]      load_size;
  logic            load_sign;
  logic [1:0]      addr_lo;
  logic            reg_we;
  logic [AW-1:0]   dest_reg;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            gpr_we;
  logic [AW-1:0]   gpr_waddr;
  logic [DW-1:0]   gpr_wdata;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  writeback_unit #(.DATA_W(DW), .NSRC(NS), .SEL_W(SW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_sel(src_sel), .is_load(is_load), .load_size(load_size),
    .load_sign(load_sign), .addr_lo(addr_lo), .reg_we(reg_we), .dest_reg(dest_reg),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (per-cycle expectation) ----------------
  bit          m_ready, m_busy, m_we, m_pend;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [4:0]  p_dest;
  bit          p_we, p_sign;
  logic [1:0]  p_size, p_lo;

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz, bit sg, logic [1:0] lo);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
      return v;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (lo / 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
      return v;
    end
    return w;
  endfunction

  function automatic void m_write(logic [4:0] d, bit we, logic [31:0] data);
    if (we && d != 5'd0) begin
      m_we = 1'b1; m_waddr = d; m_wdata = data;
    end
  endfunction

  function automatic void model_step();
    logic [31:0] src;
    if (!rst_n) begin
      m_ready = 0; m_busy = 0; m_we = 0; m_pend = 0; m_waddr = '0; m_wdata = '0;
      return;
    end
    m_we = 0;
    if (m_pend) begin
      if (flush) m_pend = 0;
      else if (mem_rvalid) begin
        m_write(p_dest, p_we, ref_load(mem_rdata, p_size, p_sign, p_lo));
        m_pend = 0;
      end
    end else if (in_valid && m_ready && !flush) begin
      if (!is_load) begin
        src = (int'(src_sel) < NS) ? src_data[src_sel*DW +: DW] : 32'd0;
        m_write(dest_reg, reg_we, src);
      end else if (mem_rvalid) begin
        m_write(dest_reg, reg_we, ref_load(mem_rdata, load_size, load_sign, addr_lo));
      end else begin
        m_pend = 1; p_dest = dest_reg; p_we = reg_we;
        p_size = load_size; p_sign = load_sign; p_lo = addr_lo;
      end
    end
    m_ready = !m_pend;
    m_busy  = m_pend;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("m_gpr_we",   32'(gpr_we),    32'(m_we));
    chk("m_gpr_waddr", 32'(gpr_waddr), 32'(m_waddr));
    chk("m_gpr_wdata", gpr_wdata,     m_wdata);
    chk("m_in_ready", 32'(in_ready),  32'(m_ready));
    chk("m_busy",     32'(busy),      32'(m_busy));
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; is_load = 0; load_size = 2'd0; load_sign = 0;
    addr_lo = 2'd0; reg_we = 0; dest_reg = 5'd0; src_sel = 2'd0; mem_rvalid = 0;
    mem_rdata = 32'd0; src_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic load_op(logic [1:0] sz, logic sg, logic [1:0] lo, logic [4:0] d, logic rv, logic [31:0] md);
    in_valid = 1; is_load = 1; load_size = sz; load_sign = sg; addr_lo = lo;
    reg_we = 1; dest_reg = d; mem_rvalid = rv; mem_rdata = md;
  endtask

  typedef struct {
    logic        ld;  logic [1:0] sz;  logic sg;  logic [1:0] lo;
    logic [1:0]  sel; logic [31:0] val; logic [31:0] mem;
    logic [4:0]  dest; logic we; logic exp_we; logic [31:0] exp_d;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 32'h0000_1234, 32'd0,        5'd5,  1'b1, 1'b1, 32'h0000_1234};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 32'h0040_0008, 32'd0,        5'd31, 1'b1, 1'b1, 32'h0040_0008};
    tbl[2] = '{1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 32'h0040_0008, 32'd0,        5'd0,  1'b1, 1'b0, 32'd0};
    tbl[3] = '{1'b1, 2'd0, 1'b1, 2'd2, 2'd0, 32'd0,         32'h1280_3456, 5'd7,  1'b1, 1'b1, 32'hFFFF_FF80};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 2'd2, 2'd0, 32'd0,         32'h1280_3456, 5'd7,  1'b1, 1'b1, 32'h0000_0080};
    tbl[5] = '{1'b1, 2'd1, 1'b1, 2'd0, 2'd0, 32'd0,         32'h1234_8765, 5'd8,  1'b1, 1'b1, 32'hFFFF_8765};
    tbl[6] = '{1'b1, 2'd1, 1'b0, 2'd3, 2'd0, 32'd0,         32'h8001_0000, 5'd9,  1'b1, 1'b1, 32'h0000_8001};
    tbl[7] = '{1'b1, 2'd3, 1'b1, 2'd1, 2'd0, 32'd0,         32'hCAFE_F00D, 5'd10, 1'b1, 1'b1, 32'hCAFE_F00D};
    tbl[8] = '{1'b1, 2'd0, 1'b1, 2'd3, 2'd0, 32'd0,         32'h7F00_0000, 5'd11, 1'b1, 1'b1, 32'h0000_007F};
    tbl[9] = '{1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 32'hDEAD_BEEF, 32'd0,        5'd4,  1'b0, 1'b0, 32'd0};

    // reset: everything zero, ready comes up the cycle after release
    idle_inputs();
    rst_n = 0;
    cycle(); cycle();
    chk("rst_gpr_we", 32'(gpr_we), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1;
    cycle();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // single-cycle vectors from the table
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      in_valid = 1; is_load = tbl[i].ld; load_size = tbl[i].sz; load_sign = tbl[i].sg;
      addr_lo = tbl[i].lo; src_sel = tbl[i].sel; src_data[tbl[i].sel*DW +: DW] = tbl[i].val;
      mem_rvalid = 1; mem_rdata = tbl[i].mem; dest_reg = tbl[i].dest; reg_we = tbl[i].we;
      cycle();
      chk($sformatf("tbl%0d_we", i), 32'(gpr_we), 32'(tbl[i].exp_we));
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_waddr", i), 32'(gpr_waddr), 32'(tbl[i].dest));
        chk($sformatf("tbl%0d_wdata", i), gpr_wdata, tbl[i].exp_d);
      end
    end

    // late halfword load: busy for three cycles, then one write
    idle_inputs();
    load_op(2'd1, 1'b1, 2'd2, 5'd12, 1'b0, 32'd0);
    cycle();
    chk("late_busy0", 32'(busy), 32'd1);
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("late_busy", 32'(busy), 32'd1);
      chk("late_ready", 32'(in_ready), 32'd0);
    end
    mem_rvalid = 1; mem_rdata = 32'h8001_0000;
    cycle();
    chk("late_we", 32'(gpr_we), 32'd1);
    chk("late_wdata", gpr_wdata, 32'hFFFF_8001);
    chk("late_waddr", 32'(gpr_waddr), 32'd12);
    chk("late_busy_end", 32'(busy), 32'd0);
    mem_rvalid = 0;
    cycle();
    chk("late_we_pulse", 32'(gpr_we), 32'd0);

    // flush and data arriving together while waiting: no write
    load_op(2'd2, 1'b0, 2'd0, 5'd13, 1'b0, 32'd0);
    cycle();
    in_valid = 0; flush = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    cycle();
    chk("flush_wait_we", 32'(gpr_we), 32'd0);
    chk("flush_wait_ready", 32'(in_ready), 32'd1);
    flush = 0; mem_rvalid = 0;
    cycle();
    chk("flush_wait_after", 32'(gpr_we), 32'd0);

    // flush in IDLE blocks the accept
    idle_inputs();
    in_valid = 1; reg_we = 1; dest_reg = 5'd3; flush = 1;
    cycle();
    chk("flush_idle_we", 32'(gpr_we), 32'd0);

    // back-to-back ALU ops write every cycle
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; reg_we = 1; dest_reg = 5'(i + 1); src_sel = 2'(i);
      src_data[i*DW +: DW] = 32'h100 + 32'(i);
      cycle();
      chk("b2b_we", 32'(gpr_we), 32'd1);
      chk("b2b_wdata", gpr_wdata, 32'h100 + 32'(i));
    end

    // reset while waiting abandons the load
    idle_inputs();
    load_op(2'd2, 1'b0, 2'd0, 5'd14, 1'b0, 32'd0);
    cycle();
    in_valid = 0; rst_n = 0;
    cycle();
    chk("rst_wait_busy", 32'(busy), 32'd0);
    chk("rst_wait_waddr", 32'(gpr_waddr), 32'd0);
    chk("rst_wait_wdata", gpr_wdata, 32'd0);
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    cycle();
    chk("rst_wait_no_we", 32'(gpr_we), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      in_valid   = $urandom_range(0, 1);
      is_load    = $urandom_range(0, 1);
      load_size  = 2'($urandom);
      load_sign  = $urandom_range(0, 1);
      addr_lo    = 2'($urandom);
      reg_we     = ($urandom_range(0, 5) != 0);
      dest_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      src_sel    = 2'($urandom);
      src_data   = {$urandom, $urandom, $urandom, $urandom};
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
